datapath_mdu: RTL and testbench

Parametrised successor to the single-bus CPU datapath. It holds a NUM_REGS x WIDTH register file, Y/Z/HI/LO temporaries, a one-hot bus with conflict detection, a combinational ALU, and an iterative multiply/divide unit (MDU) with a start/busy/done handshake. The MDU writes Z directly on completion. Memory, PC and IR stay outside and drive the bus through ext_data.

---
 rtl/datapath_mdu_if.sv | 46 ++++
 rtl/datapath_mdu.sv | 272 +++++++++++++++++++++++++++
 tb/tb_datapath_mdu.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_mdu_if.sv
// datapath_mdu_if: control, bus and MDU handshake signals of datapath_mdu.
//   master : controller side (drives the selects, strobes, ext_data and start/op)
//   slave  : datapath side (returns bus_out, bus_conflict, busy/done/err)
// Parameters: WIDTH (datapath width), RSW (register select width).
interface datapath_mdu_if #(
  parameter int WIDTH = 32,
  parameter int RSW   = 4
);
  logic [RSW-1:0]   rsel_in;
  logic             rin;
  logic [RSW-1:0]   rsel_out;
  logic             rout;
  logic             baout;
  logic             hiin;
  logic             loin;
  logic             hiout;
  logic             loout;
  logic             yin;
  logic             zin;
  logic             zhighout;
  logic             zlowout;
  logic [WIDTH-1:0] ext_data;
  logic             ext_out;
  logic [3:0]       alu_op;
  logic             mdu_start;
  logic [1:0]       mdu_op;
  logic             mdu_busy;
  logic             mdu_done;
  logic             mdu_err;
  logic [WIDTH-1:0] bus_out;
  logic             bus_conflict;

  modport master (
    output rsel_in, rin, rsel_out, rout, baout, hiin, loin, hiout, loout,
           yin, zin, zhighout, zlowout, ext_data, ext_out, alu_op,
           mdu_start, mdu_op,
    input  mdu_busy, mdu_done, mdu_err, bus_out, bus_conflict
  );

  modport slave (
    input  rsel_in, rin, rsel_out, rout, baout, hiin, loin, hiout, loout,
           yin, zin, zhighout, zlowout, ext_data, ext_out, alu_op,
           mdu_start, mdu_op,
    output mdu_busy, mdu_done, mdu_err, bus_out, bus_conflict
  );
endinterface

// File: rtl/datapath_mdu.sv
// datapath_mdu: single-bus CPU datapath with register file, Y/Z/HI/LO
// temporaries, combinational ALU and an iterative multiply/divide unit.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   dp    : datapath_mdu_if.slave (register/temp strobes, bus drivers,
//           ext_data, alu_op, MDU start/op/busy/done/err, bus_out, bus_conflict)
// Build option: MDU_DIV_EN compiles the divider; without it a divide start
// is rejected with a single mdu_err pulse and Z is left untouched.
module datapath_mdu #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int RSW      = $clog2(NUM_REGS)
) (
  input logic          clock,
  input logic          clear,
  datapath_mdu_if.slave dp
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} mdu_state_t;

  logic [WIDTH-1:0]   regs [NUM_REGS];
  logic [WIDTH-1:0]   y_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] z_q;

  logic [RSW-1:0]     rd_idx, wr_idx;
  logic [WIDTH-1:0]   reg_src;
  logic [WIDTH-1:0]   bus;
  logic [2:0]         drv_cnt;

  assign rd_idx = dp.rsel_out;
  assign wr_idx = dp.rsel_in;

  // Bus: drivers are OR-merged, then forced to zero unless exactly one is on.
  always_comb begin
    reg_src = regs[rd_idx];
    if (dp.baout && rd_idx == '0) reg_src = '0;
    drv_cnt = {2'b0, dp.rout} + {2'b0, dp.hiout} + {2'b0, dp.loout} +
              {2'b0, dp.zhighout} + {2'b0, dp.zlowout} + {2'b0, dp.ext_out};
    bus = ({WIDTH{dp.rout}}     & reg_src) |
          ({WIDTH{dp.hiout}}    & hi_q) |
          ({WIDTH{dp.loout}}    & lo_q) |
          ({WIDTH{dp.zhighout}} & z_q[2*WIDTH-1:WIDTH]) |
          ({WIDTH{dp.zlowout}}  & z_q[WIDTH-1:0]) |
          ({WIDTH{dp.ext_out}}  & dp.ext_data);
    if (drv_cnt != 3'd1) bus = '0;
  end

  assign dp.bus_out      = bus;
  assign dp.bus_conflict = (drv_cnt > 3'd1);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (dp.rin) begin
      regs[wr_idx] <= bus;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      y_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (dp.yin)  y_q  <= bus;
      if (dp.hiin) hi_q <= bus;
      if (dp.loin) lo_q <= bus;
    end
  end

  // ALU: A = Y, B = bus.
  logic [WIDTH-1:0]   alu_a, alu_b, alu_low;
  logic [SHW-1:0]     shamt;
  logic               alu_sext;
  logic [2*WIDTH-1:0] rot_l, rot_r, alu_res;

  always_comb begin
    alu_a    = y_q;
    alu_b    = bus;
    shamt    = alu_b[SHW-1:0];
    rot_l    = {alu_a, alu_a} << shamt;
    rot_r    = {alu_a, alu_a} >> shamt;
    alu_low  = '0;
    alu_sext = 1'b0;
    case (dp.alu_op)
      4'd0:  begin alu_low = alu_a + alu_b; alu_sext = 1'b1; end
      4'd1:  begin alu_low = alu_a - alu_b; alu_sext = 1'b1; end
      4'd2:  alu_low = alu_a & alu_b;
      4'd3:  alu_low = alu_a | alu_b;
      4'd4:  alu_low = alu_a >> shamt;
      4'd5:  alu_low = $signed(alu_a) >>> shamt;
      4'd6:  alu_low = alu_a << shamt;
      4'd7:  alu_low = rot_r[WIDTH-1:0];
      4'd8:  alu_low = rot_l[2*WIDTH-1:WIDTH];
      4'd9:  begin alu_low = -alu_b; alu_sext = 1'b1; end
      4'd10: alu_low = ~alu_b;
      4'd11: begin alu_low = alu_b + 1'b1; alu_sext = 1'b1; end
      default: alu_low = '0;
    endcase
    alu_res = alu_sext ? {{WIDTH{alu_low[WIDTH-1]}}, alu_low}
                       : {{WIDTH{1'b0}}, alu_low};
  end

  // MDU
  mdu_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, opb_q;
  logic               neg_hi_q;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] fin_res;
`ifdef MDU_DIV_EN
  logic               is_div_q, neg_lo_q, dz_q;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
`else
  logic               rej_q;
`endif

  always_comb begin
    a_neg   = dp.mdu_op[0] & y_q[WIDTH-1];
    b_neg   = dp.mdu_op[0] & bus[WIDTH-1];
    a_mag   = a_neg ? -y_q : y_q;
    b_mag   = b_neg ? -bus : bus;
    // Multiplier lives in acc_lo and is shifted out LSB-first while the
    // partial product enters acc_hi from the top.
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
`ifdef MDU_DIV_EN
    // Dividend shifts out of acc_lo MSB-first into the remainder in acc_hi;
    // quotient bits fill acc_lo from the bottom. Remainder < divisor, so the
    // W-bit difference is exact.
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opb_q});
    div_diff = div_sh[WIDTH-1:0] - opb_q;
`endif
  end

  // Sign correction: a product is negated as a whole; a quotient and
  // remainder are negated independently.
  always_comb begin
    fin_res = {acc_hi_q, acc_lo_q};
    if (neg_hi_q) fin_res = -fin_res;
`ifdef MDU_DIV_EN
    if (is_div_q) begin
      fin_res[2*WIDTH-1:WIDTH] = neg_hi_q ? -acc_hi_q : acc_hi_q;
      fin_res[WIDTH-1:0]       = neg_lo_q ? -acc_lo_q : acc_lo_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dp.mdu_start) begin
          if (dp.mdu_op[1]) begin
`ifdef MDU_DIV_EN
            state_d = (bus == '0) ? FIN : RUN;
`else
            state_d = IDLE;
`endif
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN:     if (cnt_q == CW'(1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      neg_hi_q <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      dz_q     <= 1'b0;
`else
      rej_q    <= 1'b0;
`endif
    end else begin
`ifndef MDU_DIV_EN
      rej_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (dp.mdu_start) begin
            if (dp.mdu_op[1]) begin
`ifdef MDU_DIV_EN
              is_div_q <= 1'b1;
              if (bus == '0) begin
                // Result preloaded so FIN's normal path emits {dividend, all ones}.
                acc_hi_q <= y_q;
                acc_lo_q <= '1;
                neg_hi_q <= 1'b0;
                neg_lo_q <= 1'b0;
                dz_q     <= 1'b1;
              end else begin
                acc_hi_q <= '0;
                acc_lo_q <= a_mag;
                opb_q    <= b_mag;
                neg_hi_q <= a_neg;
                neg_lo_q <= a_neg ^ b_neg;
                dz_q     <= 1'b0;
                cnt_q    <= CW'(WIDTH);
              end
`else
              rej_q <= 1'b1;
`endif
            end else begin
              acc_hi_q <= '0;
              acc_lo_q <= b_mag;
              opb_q    <= a_mag;
              neg_hi_q <= a_neg ^ b_neg;
              cnt_q    <= CW'(WIDTH);
`ifdef MDU_DIV_EN
              is_div_q <= 1'b0;
              dz_q     <= 1'b0;
`endif
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            acc_hi_q <= div_ge ? div_diff : div_sh[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
          end else
`endif
          begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Z: an MDU completion takes priority over a coincident zin.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)              z_q <= '0;
    else if (state_q == FIN) z_q <= fin_res;
    else if (dp.zin)         z_q <= alu_res;
  end

  assign dp.mdu_busy = (state_q == RUN);
  assign dp.mdu_done = (state_q == FIN);
`ifdef MDU_DIV_EN
  assign dp.mdu_err  = (state_q == FIN) && dz_q;
`else
  assign dp.mdu_err  = rej_q;
`endif

endmodule

// File: tb/tb_datapath_mdu.sv
module tb_datapath_mdu;
  localparam int W = 32;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  datapath_mdu_if #(.WIDTH(W), .RSW(4)) dif ();

  datapath_mdu #(.WIDTH(W), .NUM_REGS(16)) dut (
    .clock (clock),
    .clear (clear),
    .dp    (dif)
  );

  logic stim_zlo = 1'b0, stim_zhi = 1'b0, mon_zlo = 1'b0, mon_zhi = 1'b0;
  assign dif.zlowout  = stim_zlo | mon_zlo;
  assign dif.zhighout = stim_zhi | mon_zhi;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] z;
    logic        done;
    logic        err;
    int          busy;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] z_model = '0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic exp_t mdu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb2;
    int     ia, ib;
    e.done = 1'b1; e.err = 1'b0; e.busy = W; e.z = '0;
    case (op)
      2'd0: e.z = {32'b0, a} * {32'b0, b};
      2'd1: begin
        sa = $signed(a); sb2 = $signed(b);
        e.z = sa * sb2;
      end
      default: begin
`ifdef MDU_DIV_EN
        if (b == 0) begin
          e.z = {a, 32'hFFFF_FFFF}; e.err = 1'b1; e.busy = 0;
        end else if (op == 2'd2) begin
          e.z = {a % b, a / b};
        end else begin
          ia = a; ib = b;
          e.z = {32'(ia % ib), 32'(ia / ib)};
        end
`else
        e.done = 1'b0; e.err = 1'b1; e.busy = 0; e.z = z_model;
`endif
      end
    endcase
    return e;
  endfunction

  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        sx;
    int          sh;
    sh = int'(b[4:0]);
    r  = a;
    sx = 1'b0;
    case (op)
      4'd0:  begin r = a + b; sx = 1'b1; end
      4'd1:  begin r = a - b; sx = 1'b1; end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a >> sh;
      4'd5:  repeat (sh) r = {r[31], r[31:1]};
      4'd6:  r = a << sh;
      4'd7:  repeat (sh) r = {r[0], r[31:1]};
      4'd8:  repeat (sh) r = {r[30:0], r[31]};
      4'd9:  begin r = 32'd0 - b; sx = 1'b1; end
      4'd10: r = ~b;
      4'd11: begin r = b + 32'd1; sx = 1'b1; end
      default: r = '0;
    endcase
    return sx ? {{32{r[31]}}, r} : {32'b0, r};
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [31:0] lo, hi;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!clear) begin
        busy_cnt = 0;
      end else begin
        if (dif.mdu_busy) busy_cnt++;
        if (dif.mdu_done || dif.mdu_err) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion: done=%b err=%b, expected no completion", dif.mdu_done, dif.mdu_err);
          end else begin
            e = sb[0];
            check("mdu_done", {63'b0, dif.mdu_done}, {63'b0, e.done});
            check("mdu_err", {63'b0, dif.mdu_err}, {63'b0, e.err});
            check("busy_cycles", 64'(busy_cnt), 64'(e.busy));
            busy_cnt = 0;
            @(negedge clock);
            mon_zlo = 1'b1; #1 lo = dif.bus_out; mon_zlo = 1'b0;
            mon_zhi = 1'b1; #1 hi = dif.bus_out; mon_zhi = 1'b0;
            check("mdu_z", {hi, lo}, e.z);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    dif.rsel_in = '0; dif.rin = 0; dif.rsel_out = '0; dif.rout = 0; dif.baout = 0;
    dif.hiin = 0; dif.loin = 0; dif.hiout = 0; dif.loout = 0; dif.yin = 0; dif.zin = 0;
    dif.ext_data = '0; dif.ext_out = 0; dif.alu_op = '0; dif.mdu_start = 0; dif.mdu_op = '0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] v);
    dif.rsel_in = 4'(idx); dif.ext_data = v; dif.ext_out = 1; dif.rin = 1;
    step(); idle_in();
  endtask

  task automatic read_reg(input int idx, output logic [31:0] v);
    dif.rsel_out = 4'(idx); dif.rout = 1; #1 v = dif.bus_out; idle_in();
  endtask

  task automatic load_y(input logic [31:0] v);
    dif.ext_data = v; dif.ext_out = 1; dif.yin = 1;
    step(); idle_in();
  endtask

  task automatic read_z(output logic [63:0] z);
    stim_zlo = 1; #1 z[31:0] = dif.bus_out; stim_zlo = 0;
    stim_zhi = 1; #1 z[63:32] = dif.bus_out; stim_zhi = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin step(); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL mdu_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic mdu_push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = mdu_model(op, a, b);
    sb.push_back(e);
    z_model = e.z;
  endtask

  task automatic mdu_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    load_y(a);
    mdu_push(op, a, b);
    dif.ext_data = b; dif.ext_out = 1; dif.mdu_start = 1; dif.mdu_op = op;
    step(); idle_in();
    wait_drain();
  endtask

  task automatic alu_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [63:0] z;
    load_y(a);
    dif.ext_data = b; dif.ext_out = 1; dif.alu_op = op; dif.zin = 1;
    step(); idle_in();
    z_model = alu_model(op, a, b);
    read_z(z);
    check(name, z, z_model);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v, a, b;
    logic [63:0] z;
    logic [1:0]  op;
    clear = 1'b0;
    idle_in();
    repeat (3) @(posedge clock);
    #1 clear = 1'b1;

    // reset state
    check("rst_busy", {63'b0, dif.mdu_busy}, 64'd0);
    check("rst_done", {63'b0, dif.mdu_done}, 64'd0);
    check("rst_err", {63'b0, dif.mdu_err}, 64'd0);
    check("rst_bus_idle", {32'b0, dif.bus_out}, 64'd0);
    read_reg(5, v);  check("rst_reg5", {32'b0, v}, 64'd0);
    read_reg(15, v); check("rst_reg15", {32'b0, v}, 64'd0);
    read_z(z);       check("rst_z", z, 64'd0);
    dif.hiout = 1; #1 check("rst_hi", {32'b0, dif.bus_out}, 64'd0); idle_in();

    // bus sources, base-address read, conflict
    write_reg(0, 32'h1234);
    write_reg(1, 32'hAB);
    dif.rsel_out = 0; dif.rout = 1; dif.baout = 1;
    #1 check("baout_reg0", {32'b0, dif.bus_out}, 64'd0);
    dif.baout = 0;
    #1 check("reg0_plain", {32'b0, dif.bus_out}, 64'h1234);
    dif.rsel_out = 1; dif.baout = 1;
    #1 check("baout_reg1", {32'b0, dif.bus_out}, 64'hAB);
    dif.baout = 0; dif.ext_out = 1; dif.ext_data = 32'h5555;
    #1 check("conflict_bus", {32'b0, dif.bus_out}, 64'd0);
    check("conflict_flag", {63'b0, dif.bus_conflict}, 64'd1);
    dif.rout = 0;
    #1 check("single_no_conflict", {63'b0, dif.bus_conflict}, 64'd0);
    idle_in();
    dif.rsel_in = 1; dif.rsel_out = 1; dif.rin = 1; dif.rout = 1;
    step(); idle_in();
    read_reg(1, v); check("rin_rout_same", {32'b0, v}, 64'hAB);
    dif.ext_data = 32'h5555AAAA; dif.ext_out = 1; dif.hiin = 1; step(); idle_in();
    dif.ext_data = 32'h00000F0F; dif.ext_out = 1; dif.loin = 1; step(); idle_in();
    dif.hiout = 1; #1 check("hi_load", {32'b0, dif.bus_out}, 64'h5555AAAA); idle_in();
    dif.loout = 1; #1 check("lo_load", {32'b0, dif.bus_out}, 64'h0F0F); idle_in();

    // signed multiply 7 * -6 with operands from the register file
    write_reg(3, 32'd7);
    dif.rsel_out = 3; dif.rout = 1; dif.yin = 1; step(); idle_in();
    write_reg(5, 32'hFFFFFFFA);
    mdu_push(2'b01, 32'd7, 32'hFFFFFFFA);
    check("tp1_model", z_model, 64'hFFFFFFFF_FFFFFFD6);
    dif.rsel_out = 5; dif.rout = 1; dif.mdu_start = 1; dif.mdu_op = 2'b01;
    step(); idle_in();
    wait_drain();

    // ALU directed
    alu_run(4'd8, 32'h80000001, 32'd1, "alu_rol");
    alu_run(4'd5, 32'h80000001, 32'd1, "alu_shra");
    alu_run(4'd1, 32'd3, 32'd5, "alu_sub_sext");
    alu_run(4'd15, 32'h1234, 32'h5678, "alu_undef");

    // division directed (rejected when the divider is not built)
    mdu_run(2'b11, 32'd100, 32'd7);
    mdu_run(2'b11, 32'hFFFFFF9C, 32'd7);
    mdu_run(2'b10, 32'd5, 32'd0);
    mdu_run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // randomized ALU and MDU
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 40));
      alu_run(4'($urandom_range(0, 15)), a, b, "alu_rand");
    end
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
      if (op == 2'b11 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      mdu_run(op, a, b);
    end

    // zin coinciding with the completion cycle is dropped
    load_y(32'd1000);
    mdu_push(2'b00, 32'd1000, 32'd3000);
    dif.ext_data = 32'd3000; dif.ext_out = 1; dif.mdu_start = 1; dif.mdu_op = 2'b00;
    step(); idle_in();
    for (int i = 0; i < 100 && !dif.mdu_done; i++) step();
    if (!dif.mdu_done) begin
      checks++; errors++;
      $display("FAIL fin_wait: done=0 expected 1");
    end
    dif.ext_data = 32'd1; dif.ext_out = 1; dif.alu_op = 4'd0; dif.zin = 1;
    step(); idle_in();
    wait_drain();

    // second start during RUN is ignored
    load_y(32'd12345);
    mdu_push(2'b00, 32'd12345, 32'd678);
    dif.ext_data = 32'd678; dif.ext_out = 1; dif.mdu_start = 1; dif.mdu_op = 2'b00;
    step(); idle_in();
    repeat (5) step();
    dif.ext_data = 32'd9; dif.ext_out = 1; dif.mdu_start = 1; dif.mdu_op = 2'b01;
    step(); idle_in();
    wait_drain();
    repeat (40) step();

    // reset aborts an operation in flight
    load_y(32'd123);
    dif.ext_data = 32'd456; dif.ext_out = 1; dif.mdu_start = 1; dif.mdu_op = 2'b00;
    step(); idle_in();
    repeat (10) step();
    check("run_before_clear", {63'b0, dif.mdu_busy}, 64'd1);
    clear = 1'b0;
    #1 check("clear_busy", {63'b0, dif.mdu_busy}, 64'd0);
    check("clear_done", {63'b0, dif.mdu_done}, 64'd0);
    read_z(z); check("clear_z", z, 64'd0);
    read_reg(3, v); check("clear_reg3", {32'b0, v}, 64'd0);
    step();
    clear = 1'b1;
    z_model = '0;
    repeat (40) step();
    mdu_run(2'b01, 32'hFFFFFF00, 32'd77);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
